multi_register: RTL and testbench

//  Parameterised multi-function register: parallel load, increment, decrement,

---
 rtl/multi_register_pkg.sv | 15 +
 rtl/multi_register_next.sv | 49 ++++
 rtl/multi_register.sv | 44 ++++
 tb/tb_multi_register.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/multi_register_pkg.sv
// Shared types for the multi-function register: operation encoding and default width.
package multi_register_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_DEC,
        OP_SHL,
        OP_SHR,
        OP_LOAD
    } op_e;

endpackage

// File: rtl/multi_register_next.sv
// Combinational next-state logic: priority-decodes the request lines into one op
// and computes the value the register should take on the next edge.
module multi_register_next
    import multi_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             shl,
    input  logic             shr,
    output op_e              op,
    output logic [WIDTH-1:0] nxt
);

    // en is tested first so unknowns on the request lines cannot leak through while disabled.
    always_comb begin
        op = OP_HOLD;
        if (!en) begin
            op = OP_HOLD;
        end else if (inc) begin
            op = OP_INC;
        end else if (dec) begin
            op = OP_DEC;
        end else if (shl) begin
            op = OP_SHL;
        end else if (shr) begin
            op = OP_SHR;
        end else begin
            op = OP_LOAD;
        end
    end

    always_comb begin
        nxt = cur;
        case (op)
            OP_INC:  nxt = cur + WIDTH'(1);
            OP_DEC:  nxt = cur - WIDTH'(1);
            OP_SHL:  nxt = {cur[WIDTH-2:0], 1'b0};
            OP_SHR:  nxt = {1'b0, cur[WIDTH-1:1]};
            OP_LOAD: nxt = in;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/multi_register.sv
// Multi-function register: load, increment, decrement, logical shifts, with global enable.
// Holds only the state flop; all operation decoding lives in multi_register_next.
module multi_register
    import multi_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic             clk,
    input  logic             en,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             shl,
    input  logic             shr
);

    op_e              op;
    logic [WIDTH-1:0] nxt;

    multi_register_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .cur(out),
        .in (in),
        .en (en),
        .inc(inc),
        .dec(dec),
        .shl(shl),
        .shr(shr),
        .op (op),
        .nxt(nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (op != OP_HOLD) begin
            out <= nxt;
        end
    end

endmodule

// File: tb/tb_multi_register.sv
// Directed bench for multi_register: the driver pushes hand-computed expected values,
// a monitor pops and compares one value after every rising edge.
module tb_multi_register;

    logic       clk;
    logic       reset;
    logic       en;
    logic       inc;
    logic       dec;
    logic       shl;
    logic       shr;
    logic [3:0] in;
    logic [3:0] out;

    logic [3:0] exp_q[$];
    string      lbl_q[$];
    int         checks;
    int         failures;

    multi_register #(.WIDTH(4)) dut (
        .out  (out),
        .in   (in),
        .clk  (clk),
        .en   (en),
        .reset(reset),
        .inc  (inc),
        .dec  (dec),
        .shl  (shl),
        .shr  (shr)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // driver: apply one cycle of inputs at the falling edge, queue the value due after the next rising edge
    task automatic drive(input string name, input logic r, input logic e, input logic i,
                         input logic d, input logic sl, input logic sr,
                         input logic [3:0] data, input logic [3:0] expv);
        @(negedge clk);
        reset = r;
        en    = e;
        inc   = i;
        dec   = d;
        shl   = sl;
        shr   = sr;
        in    = data;
        exp_q.push_back(expv);
        lbl_q.push_back(name);
    endtask

    // disabled cycle with arbitrary op bits and data: the register must hold
    task automatic drive_idle(input string name, input logic r, input logic [3:0] expv);
        drive(name, r, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), expv);
    endtask

    // scoreboard monitor
    initial begin
        logic [3:0] e;
        string      l;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                l = lbl_q.pop_front();
                check(l, out, e);
            end
        end
    end

    initial begin
        logic [3:0] seq3[12];
        logic [3:0] seq5a[4];
        logic [3:0] seq5b[4];
        int         wait_cycles;
        checks   = 0;
        failures = 0;
        reset = 1'b0;
        en    = 1'b0;
        inc   = 1'b1;
        dec   = 1'b1;
        shl   = 1'b0;
        shr   = 1'b1;
        in    = 4'd7;

        // 1: asynchronous reset, then held through disabled cycles
        #1 reset = 1'b1;
        #1 check("rst_async", out, 4'd0);
        for (int k = 0; k < 20; k++) drive_idle("rst_hold", 1'b1, 4'd0);

        // 2: parallel load, then hold while disabled
        for (int k = 0; k < 3; k++) drive("load5", 1'b0, 1'b1, 0, 0, 0, 0, 4'd5, 4'd5);
        for (int k = 0; k < 3; k++) drive_idle("hold5", 1'b0, 4'd5);

        // 3: increment with wrap 15 -> 0
        seq3 = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
        for (int k = 0; k < 12; k++) drive("inc_wrap", 1'b0, 1'b1, 1, 0, 0, 0, 4'd0, seq3[k]);

        // 4: shift left drops the top bit; inc beats shl
        drive("load12", 1'b0, 1'b1, 0, 0, 0, 0, 4'd12, 4'd12);
        drive("shl", 1'b0, 1'b1, 0, 0, 1, 0, 4'd0, 4'd8);
        drive("shl", 1'b0, 1'b1, 0, 0, 1, 0, 4'd0, 4'd0);
        drive("shl", 1'b0, 1'b1, 0, 0, 1, 0, 4'd0, 4'd0);
        for (int k = 1; k <= 3; k++) drive("inc_over_shl", 1'b0, 1'b1, 1, 0, 1, 0, 4'd0, 4'(k));

        // 5: dec beats shr with borrow wrap, then shr alone with zero fill
        seq5a = '{4'd2, 4'd1, 4'd0, 4'd15};
        seq5b = '{4'd7, 4'd3, 4'd1, 4'd0};
        for (int k = 0; k < 4; k++) drive("dec_over_shr", 1'b0, 1'b1, 0, 1, 0, 1, 4'd0, seq5a[k]);
        for (int k = 0; k < 4; k++) drive("shr", 1'b0, 1'b1, 0, 0, 0, 1, 4'd9, seq5b[k]);

        // further priority corners
        drive("load6", 1'b0, 1'b1, 0, 0, 0, 0, 4'd6, 4'd6);
        drive("shl_over_shr", 1'b0, 1'b1, 0, 0, 1, 1, 4'd3, 4'd12);
        drive("dec_over_shl", 1'b0, 1'b1, 0, 1, 1, 1, 4'd3, 4'd11);
        drive("inc_over_all", 1'b0, 1'b1, 1, 1, 1, 1, 4'd3, 4'd12);

        // 6: reset between edges aborts a pending increment
        drive("load9", 1'b0, 1'b1, 0, 0, 0, 0, 4'd9, 4'd9);
        @(negedge clk);
        en  = 1'b1;
        inc = 1'b1;
        dec = 1'b0;
        shl = 1'b0;
        shr = 1'b0;
        #2 reset = 1'b1;
        #1 check("rst_mid", out, 4'd0);
        exp_q.push_back(4'd0);
        lbl_q.push_back("rst_mid_edge");
        drive("resume", 1'b0, 1'b1, 1, 0, 0, 0, 4'd0, 4'd1);
        drive("resume", 1'b0, 1'b1, 1, 0, 0, 0, 4'd0, 4'd2);
        drive_idle("hold_end", 1'b0, 4'd2);

        // drain the scoreboard within a bounded number of cycles
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
